// File: rtl/muxn_rr_if.sv
// Channel-side and consumer-side signals of the N:1 round-robin / fixed-select mux.
// master drives the channels and z_ready; slave is the mux itself.
interface muxn_rr_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
);
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N*W-1:0]  d;
   logic [N-1:0]    d_valid;
   logic [N-1:0]    d_ready;
   logic [W-1:0]    z;
   logic            z_valid;
   logic            z_ready;
   logic [SW-1:0]   z_src;

   modport master (
      output mode, sel, d, d_valid, z_ready,
      input  d_ready, z, z_valid, z_src
   );

   modport slave (
      input  mode, sel, d, d_valid, z_ready,
      output d_ready, z, z_valid, z_src
   );
endinterface

// File: rtl/muxn_rr.sv
// N-channel W-bit stream mux with valid/ready handshake and a registered output stage.
// Selection is round-robin (mode=0) or fixed via sel (mode=1).
module muxn_rr #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input logic        clk,
   input logic        rst,
   muxn_rr_if.slave   bus
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    z_q, z_d;
   logic [SW-1:0]   z_src_q, z_src_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [N-1:0]    d_ready;
   logic            ld;
   logic            gnt_vld;
   logic [SW-1:0]   gnt_idx;
   int unsigned     rr_idx;

   // Grant: first valid channel from ptr upward (wrapping), or sel when in fixed mode.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_idx  = 0;
      if (!bus.mode) begin
         for (int unsigned k = 0; k < N; k++) begin
            rr_idx = (32'(ptr_q) + k) % N;
            if (!gnt_vld && bus.d_valid[SW'(rr_idx)]) begin
               gnt_vld = 1'b1;
               gnt_idx = SW'(rr_idx);
            end
         end
      end else if (32'(bus.sel) < N) begin
         // sel >= N is only possible for non-power-of-two N and never grants
         if (bus.d_valid[bus.sel]) begin
            gnt_vld = 1'b1;
            gnt_idx = bus.sel;
         end
      end
   end

   // Output-stage FSM next state, load of z/z_src/ptr and channel ready.
   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      z_src_d = z_src_q;
      ptr_d   = ptr_q;
      d_ready = '0;
      ld      = (state_q == StEmpty) || bus.z_ready;
      if (ld) begin
         if (gnt_vld) begin
            state_d          = StFull;
            z_d              = bus.d[32'(gnt_idx) * W +: W];
            z_src_d          = gnt_idx;
            d_ready[gnt_idx] = 1'b1;
            if (!bus.mode) begin
               // explicit wrap so non-power-of-two N never overflows into an invalid index
               ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
            end
         end else begin
            state_d = StEmpty;
         end
      end
      // no handshake may complete while reset is asserted
      if (rst) begin
         d_ready = '0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         z_q     <= '0;
         z_src_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         z_src_q <= z_src_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.d_ready = d_ready;
   assign bus.z       = z_q;
   assign bus.z_valid = (state_q == StFull);
   assign bus.z_src   = z_src_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr with N=4, W=8.
module tb_muxn_rr;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   passed;
   int   total;

   muxn_rr_if #(.N(N), .W(W)) bus ();

   muxn_rr #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle before touching inputs or sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected registered output after the edge
   task automatic chk_out(input string tag, input logic v, input logic [7:0] z,
                          input logic [1:0] src);
      chk({tag, ".z_valid"}, 32'(bus.z_valid), 32'(v));
      chk({tag, ".z"}, 32'(bus.z), 32'(z));
      chk({tag, ".z_src"}, 32'(bus.z_src), 32'(src));
   endtask

   task automatic set_data(input logic [7:0] d3, input logic [7:0] d2, input logic [7:0] d1,
                           input logic [7:0] d0);
      bus.d = {d3, d2, d1, d0};
   endtask

   initial begin
      passed      = 0;
      total       = 0;
      rst         = 1'b1;
      bus.mode    = 1'b0;
      bus.sel     = 2'd0;
      bus.d_valid = 4'b1111;
      bus.z_ready = 1'b1;
      set_data(8'h43, 8'h32, 8'h21, 8'h10);

      // reset held two cycles with all channels valid
      #1;
      chk("rst0.d_ready", 32'(bus.d_ready), 32'h0);
      tick();
      chk_out("rst1", 1'b0, 8'h00, 2'd0);
      chk("rst1.d_ready", 32'(bus.d_ready), 32'h0);
      tick();
      chk_out("rst2", 1'b0, 8'h00, 2'd0);
      rst = 1'b0;
      #1;
      chk("rel.d_ready", 32'(bus.d_ready), 32'b0001);

      // round-robin over four always-valid channels
      tick(); chk_out("rr0", 1'b1, 8'h10, 2'd0);
      chk("rr0.d_ready", 32'(bus.d_ready), 32'b0010);
      tick(); chk_out("rr1", 1'b1, 8'h21, 2'd1);
      tick(); chk_out("rr2", 1'b1, 8'h32, 2'd2);
      tick(); chk_out("rr3", 1'b1, 8'h43, 2'd3);
      chk("rr3.d_ready", 32'(bus.d_ready), 32'b0001);
      tick(); chk_out("rr4", 1'b1, 8'h10, 2'd0);

      // ptr=1: grant ch2 alone to bring ptr to 3, then sparse 0011 wraps to ch0
      bus.d_valid = 4'b0100;
      tick(); chk_out("sp_c2", 1'b1, 8'h32, 2'd2);
      bus.d_valid = 4'b0011;
      #1;
      chk("sp.d_ready", 32'(bus.d_ready), 32'b0001);
      tick(); chk_out("sp0", 1'b1, 8'h10, 2'd0);
      tick(); chk_out("sp1", 1'b1, 8'h21, 2'd1);
      tick(); chk_out("sp2", 1'b1, 8'h10, 2'd0);
      bus.d_valid = 4'b0000;
      #1;
      chk("idle.d_ready", 32'(bus.d_ready), 32'h0);
      tick();
      chk("idle.z_valid", 32'(bus.z_valid), 32'h0);

      // back-pressure: ptr=1, load ch1 then stall three cycles
      bus.d_valid = 4'b1111;
      tick(); chk_out("bp_ld", 1'b1, 8'h21, 2'd1);
      bus.z_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.d_ready", 32'(bus.d_ready), 32'h0);
         tick();
         chk_out("bp_hold", 1'b1, 8'h21, 2'd1);
      end
      bus.z_ready = 1'b1;
      #1;
      chk("bp_rel.d_ready", 32'(bus.d_ready), 32'b0100);
      tick(); chk_out("bp_next", 1'b1, 8'h32, 2'd2);

      // fixed select: ptr now 3 and must hold through mode=1
      bus.mode    = 1'b1;
      bus.sel     = 2'd2;
      bus.d_valid = 4'b0100;
      set_data(8'h43, 8'hA5, 8'h21, 8'h10);
      #1;
      chk("fx.d_ready", 32'(bus.d_ready), 32'b0100);
      tick(); chk_out("fx_sel2", 1'b1, 8'hA5, 2'd2);
      bus.sel = 2'd1;
      #1;
      chk("fx_nog.d_ready", 32'(bus.d_ready), 32'h0);
      tick();
      chk("fx_nog.z_valid", 32'(bus.z_valid), 32'h0);

      // back to round-robin: resumes from held ptr=3
      bus.mode    = 1'b0;
      bus.d_valid = 4'b1111;
      set_data(8'h43, 8'h32, 8'h21, 8'h10);
      #1;
      chk("resume.d_ready", 32'(bus.d_ready), 32'b1000);
      tick(); chk_out("resume", 1'b1, 8'h43, 2'd3);

      // reset while FULL and stalled drops the word and clears ptr
      bus.z_ready = 1'b0;
      rst         = 1'b1;
      #1;
      chk("mrst.d_ready", 32'(bus.d_ready), 32'h0);
      tick();
      chk_out("mrst", 1'b0, 8'h00, 2'd0);
      rst         = 1'b0;
      bus.z_ready = 1'b1;
      #1;
      chk("post.d_ready", 32'(bus.d_ready), 32'b0001);
      tick(); chk_out("post", 1'b1, 8'h10, 2'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
